// File: rtl/unified_mem_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, the arbiter and the shared memory.
// The slave view belongs to the arbiter; the master view belongs to the surrounding pipeline and memory.
interface unified_mem_arbiter_if #(parameter int AW = 20);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [31:0]   if_rdata;
  logic          if_stall;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ack;
  logic [31:0]   d_rdata;
  logic          d_stall;
  logic          m_valid;
  logic          m_we;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic          m_ready;
  logic [31:0]   m_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ready, m_rdata,
    output if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
           m_valid, m_we, m_be, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ready, m_rdata,
    input  if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
           m_valid, m_we, m_be, m_addr, m_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port variable-latency memory between instruction fetch and load/store.
// Data wins ties; a streak counter forces a fetch grant after MAX_D_STREAK data grants.
module unified_mem_arbiter #(
  parameter int AW           = 20,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  unified_mem_arbiter_if.slave  bus
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

  state_e        state_q, state_d;
  logic          owner_d_q, owner_d_d;   // 1: data port owns the response
  logic [SW-1:0] streak_q, streak_d;
  logic          m_valid_q, m_valid_d;
  logic          m_we_q, m_we_d;
  logic [3:0]    m_be_q, m_be_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [31:0]   m_wdata_q, m_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_d_q  <= 1'b0;
      streak_q   <= '0;
      m_valid_q  <= 1'b0;
      m_we_q     <= 1'b0;
      m_be_q     <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_d_q  <= owner_d_d;
      streak_q   <= streak_d;
      m_valid_q  <= m_valid_d;
      m_we_q     <= m_we_d;
      m_be_q     <= m_be_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d_d  = owner_d_q;
    streak_d   = streak_q;
    m_valid_d  = m_valid_q;
    m_we_d     = m_we_q;
    m_be_d     = m_be_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (!bus.if_req) streak_d = '0;
        if (bus.d_req && !(bus.if_req && streak_q == STREAK_MAX)) begin
          state_d   = BUSY_D;
          m_valid_d = 1'b1;
          m_we_d    = bus.d_we;
          m_be_d    = bus.d_be;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          // A data grant here implies streak < max whenever a fetch is waiting
          if (bus.if_req) streak_d = streak_q + 1'b1;
        end else if (bus.if_req) begin
          state_d   = BUSY_I;
          m_valid_d = 1'b1;
          m_we_d    = 1'b0;
          m_be_d    = 4'hF;
          m_addr_d  = bus.if_addr;
          m_wdata_d = '0;
          streak_d  = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          owner_d_d = (state_q == BUSY_D);
          state_d   = RESP;
          if (state_q == BUSY_I)  if_rdata_d = bus.m_rdata;
          else if (!m_we_q)       d_rdata_d  = bus.m_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.if_ack   = (state_q == RESP) && !owner_d_q;
  assign bus.d_ack    = (state_q == RESP) &&  owner_d_q;
  assign bus.if_stall = bus.if_req && !bus.if_ack;
  assign bus.d_stall  = bus.d_req  && !bus.d_ack;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_be     = m_be_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed checks of the unified fetch/data memory arbiter with a hand-driven memory side.
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  unified_mem_arbiter_if #(.AW(20)) bus ();

  unified_mem_arbiter #(.AW(20), .MAX_D_STREAK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] seq;
    int         nack;
    int         both;

    reset = 1'b1;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ready = 0; bus.m_rdata = '0;
    tick(); tick();
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_m_addr",  32'(bus.m_addr), 0);
    chk("rst_m_be",    32'(bus.m_be), 0);
    chk("rst_acks",    {30'd0, bus.if_ack, bus.d_ack}, 0);
    chk("rst_rdata",   bus.if_rdata | bus.d_rdata, 0);

    // 1: fetch only, memory ready on first valid cycle
    reset = 1'b0;
    bus.if_req = 1; bus.if_addr = 20'h00010;
    bus.m_ready = 1; bus.m_rdata = 32'h00500093;
    #1;
    chk("t1_stall_c0", 32'(bus.if_stall), 1);
    chk("t1_valid_c0", 32'(bus.m_valid), 0);
    tick();
    chk("t1_valid_c1", 32'(bus.m_valid), 1);
    chk("t1_addr_c1",  32'(bus.m_addr), 32'h10);
    chk("t1_be_c1",    32'(bus.m_be), 32'hF);
    chk("t1_we_c1",    32'(bus.m_we), 0);
    chk("t1_stall_c1", 32'(bus.if_stall), 1);
    tick();
    chk("t1_ack_c2",   32'(bus.if_ack), 1);
    chk("t1_rdata",    bus.if_rdata, 32'h00500093);
    chk("t1_stall_c2", 32'(bus.if_stall), 0);
    bus.if_req = 0; bus.m_ready = 0;
    tick();
    chk("t1_ack_c3",   32'(bus.if_ack), 0);
    chk("t1_valid_c3", 32'(bus.m_valid), 0);

    // 2: simultaneous fetch and load, data wins
    bus.if_req = 1; bus.if_addr = 20'h00020;
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 20'h00100;
    bus.m_ready = 1; bus.m_rdata = 32'h11112222;
    tick();
    chk("t2_addr_d",   32'(bus.m_addr), 32'h100);
    chk("t2_we_d",     32'(bus.m_we), 0);
    chk("t2_dstall",   32'(bus.d_stall), 1);
    tick();
    chk("t2_acks_d",   {30'd0, bus.if_ack, bus.d_ack}, 1);
    chk("t2_drdata",   bus.d_rdata, 32'h11112222);
    bus.d_req = 0; bus.m_rdata = 32'h33334444;
    tick();
    chk("t2_resp_gap", {29'd0, bus.m_valid, bus.if_ack, bus.d_ack}, 0);
    tick();
    chk("t2_addr_i",   32'(bus.m_addr), 32'h20);
    chk("t2_ack_early", 32'(bus.if_ack), 0);
    tick();
    chk("t2_iack",     32'(bus.if_ack), 1);
    chk("t2_irdata",   bus.if_rdata, 32'h33334444);
    chk("t2_drdata_hold", bus.d_rdata, 32'h11112222);
    bus.if_req = 0; bus.m_ready = 0;
    tick();

    // 3: store with 5 wait cycles
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_addr = 20'h00200;
    bus.d_wdata = 32'hAABBCCDD; bus.m_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t3_m_c%0d", i), {bus.m_valid, bus.m_we, 26'd0, bus.m_be}, {2'b11, 26'd0, 4'b0011});
      chk($sformatf("t3_addr_c%0d", i), 32'(bus.m_addr), 32'h200);
      chk($sformatf("t3_wdata_c%0d", i), bus.m_wdata, 32'hAABBCCDD);
      chk($sformatf("t3_noack_c%0d", i), 32'(bus.d_ack), 0);
      if (i == 5) bus.m_ready = 1;
    end
    tick();
    chk("t3_ack",      32'(bus.d_ack), 1);
    chk("t3_valid_off", 32'(bus.m_valid), 0);
    chk("t3_drdata",   bus.d_rdata, 32'h11112222);
    bus.d_req = 0; bus.m_ready = 0;
    tick();
    chk("t3_ack_once", 32'(bus.d_ack), 0);

    // 4: sustained data traffic with a waiting fetch
    bus.if_req = 1; bus.if_addr = 20'h00040;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 20'h00300;
    bus.m_ready = 1; bus.m_rdata = 32'h55AA55AA;
    seq = '0; nack = 0; both = 0;
    for (int c = 0; c < 200 && nack < 10; c++) begin
      tick();
      if (bus.if_ack && bus.d_ack) both++;
      if (bus.if_ack) begin seq[nack] = 1'b1; nack++; end
      else if (bus.d_ack) nack++;
    end
    chk("t4_nack",     32'(nack), 10);
    chk("t4_order",    32'(seq), 32'b10_0001_0000);
    chk("t4_both",     32'(both), 0);
    bus.if_req = 0; bus.d_req = 0; bus.m_ready = 0;
    tick();

    // 6: m_ready pulse while idle
    bus.m_ready = 1; bus.m_rdata = 32'hFFFFFFFF;
    tick();
    bus.m_ready = 0;
    chk("t6_idle_out", {29'd0, bus.m_valid, bus.if_ack, bus.d_ack}, 0);
    tick();
    chk("t6_idle_ack", {30'd0, bus.if_ack, bus.d_ack}, 0);
    chk("t6_irdata",   bus.if_rdata, 32'h55AA55AA);
    chk("t6_drdata",   bus.d_rdata, 32'h55AA55AA);

    // 5: reset while a load is stuck in the memory
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 20'h00400;
    bus.if_req = 1; bus.if_addr = 20'h00080;
    tick();
    chk("t5_busy_addr", 32'(bus.m_addr), 32'h400);
    reset = 1'b1;
    tick();
    chk("t5_rst_valid", 32'(bus.m_valid), 0);
    chk("t5_rst_ack",  {30'd0, bus.if_ack, bus.d_ack}, 0);
    reset = 1'b0; bus.d_req = 0;
    bus.m_ready = 1; bus.m_rdata = 32'h12345678;
    tick();
    chk("t5_grant_i",  32'(bus.m_addr), 32'h80);
    chk("t5_noack",    32'(bus.d_ack), 0);
    tick();
    chk("t5_iack",     32'(bus.if_ack), 1);
    chk("t5_irdata",   bus.if_rdata, 32'h12345678);
    bus.if_req = 0; bus.m_ready = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
